// File: rtl/hazard_pkg.sv
// Shared constants for the hazard/forwarding controller: forward-select
// encodings and default multiply/divide occupancy latencies.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

endpackage

// File: rtl/md_busy_cnt.sv
// Multiply/divide occupancy tracker: a start loads the op latency, then the
// counter drains by one per cycle; busy whenever the counter is nonzero.
module md_busy_cnt
    import hazard_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic div_i,
    output logic busy_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A start while busy simply restarts the count with the new latency.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = div_i ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl_md.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline with HI/LO busy
// tracking. Optional stall statistics counters: define HAZARD_STALL_STAT_EN.
module hazard_ctrl_md
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rt_e,
    input  logic [REG_AW-1:0] wreg_e,
    input  logic [REG_AW-1:0] wreg_m,
    input  logic [REG_AW-1:0] wreg_w,
    input  logic              regwr_e,
    input  logic              regwr_m,
    input  logic              regwr_w,
    input  logic              memrd_e,
    input  logic              memrd_m,
    input  logic              br_d,
    input  logic              jr_d,
    input  logic              md_start_e,
    input  logic              md_div_e,
    input  logic              md_use_d,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_e,
    output logic [1:0]        fwd_a_d,
    output logic [1:0]        fwd_b_d,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              md_busy
`ifdef HAZARD_STALL_STAT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       md_stall_cnt
`endif
);

    // M-stage result wins over W; register 0 is hardwired and never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                           input logic              rw_m,
                                           input logic [REG_AW-1:0] wr_m,
                                           input logic              rw_w,
                                           input logic [REG_AW-1:0] wr_w);
        fwd_sel = FWD_RF;
        if (src != '0) begin
            if (rw_m && (wr_m == src)) begin
                fwd_sel = FWD_M;
            end else if (rw_w && (wr_w == src)) begin
                fwd_sel = FWD_W;
            end
        end
    endfunction

    md_busy_cnt #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_md_busy_cnt (
        .clk     (clk),
        .reset   (reset),
        .start_i (md_start_e),
        .div_i   (md_div_e),
        .busy_o  (md_busy)
    );

    assign fwd_a_e = fwd_sel(rs_e, regwr_m, wreg_m, regwr_w, wreg_w);
    assign fwd_b_e = fwd_sel(rt_e, regwr_m, wreg_m, regwr_w, wreg_w);
    assign fwd_a_d = (br_d || jr_d) ? fwd_sel(rs_d, regwr_m, wreg_m, regwr_w, wreg_w) : FWD_RF;
    assign fwd_b_d = br_d ? fwd_sel(rt_d, regwr_m, wreg_m, regwr_w, wreg_w) : FWD_RF;

    logic e_hit_rs, e_hit_rt, m_hit_rs, m_hit_rt;
    logic ld_use, br_e_haz, jr_e_haz, brjr_m_haz, md_haz, stall;

    assign e_hit_rs = (wreg_e != '0) && (wreg_e == rs_d);
    assign e_hit_rt = (wreg_e != '0) && (wreg_e == rt_d);
    assign m_hit_rs = (wreg_m != '0) && (wreg_m == rs_d);
    assign m_hit_rt = (wreg_m != '0) && (wreg_m == rt_d);

    assign ld_use     = memrd_e && (e_hit_rs || e_hit_rt);
    assign br_e_haz   = br_d && regwr_e && (e_hit_rs || e_hit_rt);
    assign jr_e_haz   = jr_d && regwr_e && e_hit_rs;
    // A load in M has no data to forward into D yet, so a D-stage compare must wait.
    assign brjr_m_haz = memrd_m && ((br_d && (m_hit_rs || m_hit_rt)) || (jr_d && m_hit_rs));
    assign md_haz     = md_use_d && (md_busy || md_start_e);

    assign stall   = ld_use || br_e_haz || jr_e_haz || brjr_m_haz || md_haz;
    assign stall_f = stall;
    assign stall_d = stall;
    assign flush_e = stall;

`ifdef HAZARD_STALL_STAT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] md_stall_cnt_q, md_stall_cnt_d;

    assign stall_cnt_d    = stall  ? sat_inc(stall_cnt_q)    : stall_cnt_q;
    assign md_stall_cnt_d = md_haz ? sat_inc(md_stall_cnt_q) : md_stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q    <= '0;
            md_stall_cnt_q <= '0;
        end else begin
            stall_cnt_q    <= stall_cnt_d;
            md_stall_cnt_q <= md_stall_cnt_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign md_stall_cnt = md_stall_cnt_q;
`endif

endmodule
